// File: rtl/debug_probe_viewer.sv
// Debug probe viewer: shows one LedSize-wide segment of a wide probe bus (live or triggered snapshot)
// on LEDs, selected by switches plus a debounced page button, or by a free-running auto-scroll.
module debug_probe_viewer #(
    parameter int LedSize        = 16,
    parameter int ProbeWidth     = 4096,
    parameter int SelSize        = 5,
    parameter int ScrollPeriod   = 100000000,
    parameter int DebounceCycles = 1000000,
    localparam int NumSeg        = (ProbeWidth + LedSize - 1) / LedSize,
    localparam int NumPagesRaw   = (NumSeg + (1 << SelSize) - 1) >> SelSize,
    localparam int NumPages      = (NumPagesRaw > 1) ? NumPagesRaw : 1,
    localparam int PageSize      = (NumPages > 1) ? $clog2(NumPages) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ProbeWidth-1:0] probe,
    input  logic                  trigger,
    input  logic                  rearm,
    input  logic [1:0]            mode,
    input  logic [SelSize-1:0]    sw,
    input  logic                  page_btn,
    output logic [LedSize-1:0]    led,
    output logic                  triggered,
    output logic [PageSize-1:0]   page
);

    localparam int ScrW = (NumSeg > 1) ? $clog2(NumSeg) : 1;
    localparam int IdxW = (PageSize + SelSize > ScrW) ? PageSize + SelSize : ScrW;
    localparam int CntW = (ScrollPeriod > 1) ? $clog2(ScrollPeriod) : 1;
    localparam int DebW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;

    localparam logic [CntW-1:0]     ScrollLast = CntW'(ScrollPeriod - 1);
    localparam logic [ScrW-1:0]     SegLast    = ScrW'(NumSeg - 1);
    localparam logic [DebW-1:0]     DebLast    = DebW'(DebounceCycles - 1);
    localparam logic [PageSize-1:0] PageLast   = PageSize'(NumPages - 1);

    logic [ProbeWidth-1:0]        snapshot;
    logic                         trig_prev;
    logic                         trig_rise;
    logic [CntW-1:0]              scroll_cnt;
    logic [ScrW-1:0]              scroll_idx;
    logic                         btn_sync_p0;
    logic                         btn_sync_p1;
    logic [DebW-1:0]              deb_cnt;
    logic                         deb_level;
    logic [NumSeg*LedSize-1:0]    padded;
    logic [IdxW-1:0]              idx;
    logic [LedSize-1:0]           seg_sel;

    assign trig_rise = trigger & ~trig_prev;

    // Segment mux: indices with no matching segment fall through to zero.
    always_comb begin
        padded = '0;
        padded[ProbeWidth-1:0] = mode[0] ? snapshot : probe;
        idx = mode[1] ? IdxW'(scroll_idx) : IdxW'({page, sw});
        seg_sel = '0;
        for (int k = 0; k < NumSeg; k++) begin
            if (idx == IdxW'(k)) seg_sel = padded[k*LedSize +: LedSize];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            led <= '0;
        end else begin
            led <= seg_sel;
        end
    end

    // Rearm wins over a coincident edge and leaves the snapshot untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            trig_prev <= 1'b0;
            triggered <= 1'b0;
            snapshot  <= '0;
        end else begin
            trig_prev <= trigger;
            if (rearm) begin
                triggered <= 1'b0;
            end else if (trig_rise && !triggered) begin
                triggered <= 1'b1;
                snapshot  <= probe;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !mode[1]) begin
            scroll_cnt <= '0;
            scroll_idx <= '0;
        end else if (scroll_cnt == ScrollLast) begin
            scroll_cnt <= '0;
            scroll_idx <= (scroll_idx == SegLast) ? '0 : scroll_idx + 1'b1;
        end else begin
            scroll_cnt <= scroll_cnt + 1'b1;
        end
    end

    // Page advances on the cycle the debounced level rises.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_sync_p0 <= 1'b0;
            btn_sync_p1 <= 1'b0;
            deb_cnt     <= '0;
            deb_level   <= 1'b0;
            page        <= '0;
        end else begin
            btn_sync_p0 <= page_btn;
            btn_sync_p1 <= btn_sync_p0;
            if (btn_sync_p1 != deb_level) begin
                if (deb_cnt == DebLast) begin
                    deb_cnt   <= '0;
                    deb_level <= btn_sync_p1;
                    if (btn_sync_p1) page <= (page == PageLast) ? '0 : page + 1'b1;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

endmodule
